// File: rtl/nibble_alu_pkg.sv
// Shared function-select and mode codes for the Nibbler 4-bit ALU slice.
// Logic-mode and arithmetic-mode names alias the same 4-bit codes.
package nibble_alu_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Arithmetic-mode names (with carry-in inactive).
  localparam logic [3:0] FUNC_A      = 4'b0000;
  localparam logic [3:0] FUNC_SUB    = 4'b0110;
  localparam logic [3:0] FUNC_ADD    = 4'b1001;
  localparam logic [3:0] FUNC_DOUBLE = 4'b1100;
  localparam logic [3:0] FUNC_DEC    = 4'b1111;

  // Logic-mode names.
  localparam logic [3:0] FUNC_NOT_A      = 4'b0000;
  localparam logic [3:0] FUNC_NOR        = 4'b0001;
  localparam logic [3:0] FUNC_NOTA_AND_B = 4'b0010;
  localparam logic [3:0] FUNC_ZERO       = 4'b0011;
  localparam logic [3:0] FUNC_NAND       = 4'b0100;
  localparam logic [3:0] FUNC_NOT_B      = 4'b0101;
  localparam logic [3:0] FUNC_XOR        = 4'b0110;
  localparam logic [3:0] FUNC_A_AND_NOTB = 4'b0111;
  localparam logic [3:0] FUNC_NOTA_OR_B  = 4'b1000;
  localparam logic [3:0] FUNC_XNOR       = 4'b1001;
  localparam logic [3:0] FUNC_B          = 4'b1010;
  localparam logic [3:0] FUNC_AND        = 4'b1011;
  localparam logic [3:0] FUNC_ONES       = 4'b1100;
  localparam logic [3:0] FUNC_A_OR_NOTB  = 4'b1101;
  localparam logic [3:0] FUNC_OR         = 4'b1110;
  localparam logic [3:0] FUNC_PASS_A     = 4'b1111;

endpackage

// File: rtl/nibble_alu_core.sv
// Combinational 74181-style ALU: result, carry, zero and signed overflow.
// Overflow is always computed here; the wrapper decides whether to expose it.
module nibble_alu_core
  import nibble_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             mode,
  input  logic [3:0]       func,
  input  logic             notCarryIn,
  input  logic [WIDTH-1:0] aPort,
  input  logic [WIDTH-1:0] bPort,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] xTerm;
  logic [WIDTH-1:0] yTerm;
  logic [WIDTH:0]   arithSum;
  logic [WIDTH-1:0] logicResult;
  logic             carryIntoMsb;

  // The 74181 propagate/generate-like terms, one bit slice at a time.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gSlice
      assign xTerm[gi] = aPort[gi] | (bPort[gi] & func[0]) | (~bPort[gi] & func[1]);
      assign yTerm[gi] = (aPort[gi] & ~bPort[gi] & func[2]) | (aPort[gi] & bPort[gi] & func[3]);
    end
  endgenerate

  assign arithSum = {1'b0, xTerm} + {1'b0, yTerm} + {{WIDTH{1'b0}}, ~notCarryIn};

  // Sum bit = x ^ y ^ carry-in, so the carry into the MSB can be recovered.
  assign carryIntoMsb = arithSum[WIDTH-1] ^ xTerm[WIDTH-1] ^ yTerm[WIDTH-1];

  always_comb begin
    logicResult = '0;
    case (func)
      FUNC_NOT_A:      logicResult = ~aPort;
      FUNC_NOR:        logicResult = ~(aPort | bPort);
      FUNC_NOTA_AND_B: logicResult = ~aPort & bPort;
      FUNC_ZERO:       logicResult = '0;
      FUNC_NAND:       logicResult = ~(aPort & bPort);
      FUNC_NOT_B:      logicResult = ~bPort;
      FUNC_XOR:        logicResult = aPort ^ bPort;
      FUNC_A_AND_NOTB: logicResult = aPort & ~bPort;
      FUNC_NOTA_OR_B:  logicResult = ~aPort | bPort;
      FUNC_XNOR:       logicResult = ~(aPort ^ bPort);
      FUNC_B:          logicResult = bPort;
      FUNC_AND:        logicResult = aPort & bPort;
      FUNC_ONES:       logicResult = '1;
      FUNC_A_OR_NOTB:  logicResult = aPort | ~bPort;
      FUNC_OR:         logicResult = aPort | bPort;
      FUNC_PASS_A:     logicResult = aPort;
      default:         logicResult = '0;
    endcase
  end

  always_comb begin
    if (mode == MODE_LOGIC) begin
      result   = logicResult;
      carry    = 1'b0;
      overflow = 1'b0;
    end else begin
      result   = arithSum[WIDTH-1:0];
      carry    = arithSum[WIDTH];
      overflow = carryIntoMsb ^ arithSum[WIDTH];
    end
  end

  assign zero = (result == '0);

endmodule

// File: rtl/nibble_alu.sv
// Registered 4-bit ALU slice for the Nibbler datapath.
// Define NIBBLE_ALU_OVERFLOW_EN to add the registered overflow_out port.
module nibble_alu
  import nibble_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             not_carry_in,
  input  logic             mode,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a_port,
  input  logic [WIDTH-1:0] b_port,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
`ifdef NIBBLE_ALU_OVERFLOW_EN
  output logic             overflow_out,
`endif
  output logic             zero_out
);

  logic [WIDTH-1:0] coreResult;
  logic             coreCarry;
  logic             coreZero;
  logic             coreOverflow;

  nibble_alu_core #(.WIDTH(WIDTH)) uCore (
    .mode       (mode),
    .func       (func),
    .notCarryIn (not_carry_in),
    .aPort      (a_port),
    .bPort      (b_port),
    .result     (coreResult),
    .carry      (coreCarry),
    .zero       (coreZero),
    .overflow   (coreOverflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      zero_out  <= 1'b1;
    end else begin
      data_out  <= coreResult;
      carry_out <= coreCarry;
      zero_out  <= coreZero;
    end
  end

`ifdef NIBBLE_ALU_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) overflow_out <= 1'b0;
    else       overflow_out <= coreOverflow;
  end
`else
  // Overflow is still produced by the core but deliberately left unregistered.
  logic unusedOverflow;
  assign unusedOverflow = coreOverflow;
`endif

endmodule

// File: tb/tb_nibble_alu.sv
// Directed-vector bench for nibble_alu: each vector is applied for one edge
// and the registered outputs are checked one cycle later.
module tb_nibble_alu;
  import nibble_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       notCarryIn;
  logic       mode;
  logic [3:0] func;
  logic [3:0] aPort;
  logic [3:0] bPort;
  logic [3:0] dataOut;
  logic       carryOut;
  logic       zeroOut;
`ifdef NIBBLE_ALU_OVERFLOW_EN
  logic       overflowOut;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  nibble_alu #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .not_carry_in (notCarryIn),
    .mode         (mode),
    .func         (func),
    .a_port       (aPort),
    .b_port       (bPort),
    .data_out     (dataOut),
    .carry_out    (carryOut),
`ifdef NIBBLE_ALU_OVERFLOW_EN
    .overflow_out (overflowOut),
`endif
    .zero_out     (zeroOut)
  );

  task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutputs(input string name, input logic [3:0] expData,
                              input logic expCarry, input logic expZero);
    checkVal({name, ".data"},  {4'h0, dataOut},  {4'h0, expData});
    checkVal({name, ".carry"}, {7'h0, carryOut}, {7'h0, expCarry});
    checkVal({name, ".zero"},  {7'h0, zeroOut},  {7'h0, expZero});
    $display("%-12s data=%b carry=%b zero=%b (exp %b/%b/%b)",
             name, dataOut, carryOut, zeroOut, expData, expCarry, expZero);
  endtask

  // Apply one operation, clock it in, sample just after the edge.
  task automatic runOp(input string name, input logic m, input logic [3:0] f,
                       input logic ncin, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] expData, input logic expCarry, input logic expZero);
    @(negedge clk);
    reset = 1'b0; mode = m; func = f; notCarryIn = ncin; aPort = a; bPort = b;
    @(posedge clk);
    #1;
    checkOutputs(name, expData, expCarry, expZero);
  endtask

  initial begin
    // Reset held for two edges with a carry-producing operation on the inputs.
    reset = 1'b1; mode = MODE_ARITH; func = FUNC_ADD; notCarryIn = 1'b1;
    aPort = 4'b1111; bPort = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    checkOutputs("reset", 4'b0000, 1'b0, 1'b1);

    runOp("pass_a",   MODE_ARITH, FUNC_A,   1'b1, 4'b0011, 4'b0111, 4'b0011, 1'b0, 1'b0);
    runOp("pass_b",   MODE_LOGIC, FUNC_B,   1'b1, 4'b0011, 4'b0111, 4'b0111, 1'b0, 1'b0);
    runOp("sub_borr", MODE_ARITH, FUNC_SUB, 1'b0, 4'b0011, 4'b0111, 4'b1100, 1'b0, 1'b0);
    runOp("sub_eq",   MODE_ARITH, FUNC_SUB, 1'b0, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b1);
    runOp("add",      MODE_ARITH, FUNC_ADD, 1'b1, 4'b0011, 4'b0111, 4'b1010, 1'b0, 1'b0);
    runOp("add_wrap", MODE_ARITH, FUNC_ADD, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
    runOp("dec_zero", MODE_ARITH, FUNC_DEC, 1'b1, 4'b0000, 4'b0110, 4'b1111, 1'b0, 1'b0);
    runOp("dec_five", MODE_ARITH, FUNC_DEC, 1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b1, 1'b0);
    runOp("a_plus1",  MODE_ARITH, FUNC_A,   1'b0, 4'b1001, 4'b0000, 4'b1010, 1'b0, 1'b0);
    runOp("xor_ncin", MODE_LOGIC, FUNC_XOR, 1'b0, 4'b0011, 4'b0111, 4'b0100, 1'b0, 1'b0);
    runOp("ones",     MODE_LOGIC, FUNC_ONES, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0);
    runOp("lzero",    MODE_LOGIC, FUNC_ZERO, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1);
    runOp("nor",      MODE_LOGIC, FUNC_NOR, 1'b1, 4'b0011, 4'b0111, 4'b1000, 1'b0, 1'b0);

    // Reset mid-stream overrides the live operation on the inputs.
    @(negedge clk);
    reset = 1'b1; mode = MODE_ARITH; func = FUNC_ADD; notCarryIn = 1'b0;
    aPort = 4'b0110; bPort = 4'b0001;
    @(posedge clk);
    #1;
    checkOutputs("mid_reset", 4'b0000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
